// File: rtl/bf_bus_pkg.sv
// bf_bus_pkg: shared FSM states, op encoding and width constants for the brainfuck bus responder.
package bf_bus_pkg;
  localparam int BYTE_W          = 8;
  localparam int MAX_WAIT_STATES = 15;
  localparam int WAIT_W          = $clog2(MAX_WAIT_STATES + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_MEM_WAIT, ST_ACK} state_t;
  // {space, dir}: space 0=RAM 1=IO, dir 0=read 1=write
  typedef enum logic [1:0] {
    OP_MEM_RD = 2'b00,
    OP_MEM_WR = 2'b01,
    OP_IO_RD  = 2'b10,
    OP_IO_WR  = 2'b11
  } op_t;
endpackage

// File: rtl/bf_sync_fifo.sv
// bf_sync_fifo: synchronous FIFO with extra-MSB wrap pointers; push ignored when full, pop ignored when empty.
module bf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      r_wp, r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push, w_pop;
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/bf_bus_responder.sv
// bf_bus_responder: data RAM plus RX/TX byte FIFOs behind the CPU rd/wr/mreq/ioreq/ready bus.
// BF_BUS_PROTOCOL_CHECK_EN: acknowledge illegal requests with no side effect and raise sticky err_o.
module bf_bus_responder
  import bf_bus_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int WAIT_STATES     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_ADDR_WIDTH-1:0] addr_i,
  input  logic [BYTE_W-1:0]          data_i,
  output logic [BYTE_W-1:0]          data_o,
  input  logic                       rd,
  input  logic                       wr,
  input  logic                       mreq,
  input  logic                       ioreq,
  output logic                       ready,
  input  logic [BYTE_W-1:0]          rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [BYTE_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready
`ifdef BF_BUS_PROTOCOL_CHECK_EN
  ,
  output logic                       err_o
`endif
);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  state_t                     r_state;
  op_t                        r_op;
  logic                       r_nop, r_ready;
  logic [WAIT_W-1:0]          r_cnt;
  logic [DATA_ADDR_WIDTH-1:0] r_addr;
  logic [BYTE_W-1:0]          r_data;
  logic [BYTE_W-1:0]          r_mem [2**DATA_ADDR_WIDTH];
  logic w_legal, w_mem_req, w_io_rd, w_io_wr, w_ack;
  logic w_rx_pop, w_rx_full, w_rx_empty, w_tx_push, w_tx_full, w_tx_empty, w_ram_we;
  logic [BYTE_W-1:0] w_rx_head;
  assign w_legal   = (mreq ^ ioreq) && (rd ^ wr);
  assign w_mem_req = w_legal && mreq;
  assign w_io_rd   = w_legal && ioreq && rd;
  assign w_io_wr   = w_legal && ioreq && wr;
  // side effects land on the edge that leaves ACK; illegal-request ACKs are inert
  assign w_ack     = (r_state == ST_ACK) && !r_nop;
  assign w_rx_pop  = w_ack && (r_op == OP_IO_RD);
  assign w_tx_push = w_ack && (r_op == OP_IO_WR);
  assign w_ram_we  = w_ack && (r_op == OP_MEM_WR);
  assign ready     = r_ready;
  assign data_o    = r_data;
  assign rx_ready  = !w_rx_full;
  assign tx_valid  = !w_tx_empty;
`ifdef BF_BUS_PROTOCOL_CHECK_EN
  logic r_err, w_illegal;
  assign w_illegal = (mreq || ioreq) && !w_legal;
  assign err_o     = r_err;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MEM_RD;
      r_nop   <= 1'b0;
      r_ready <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
`ifdef BF_BUS_PROTOCOL_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_nop  <= 1'b0;
          r_addr <= addr_i;
          r_op   <= op_t'({ioreq, wr});
          if (w_mem_req) begin
            if (WAIT_STATES == 0) begin
              r_state <= ST_ACK;
              r_ready <= 1'b1;
              if (rd) r_data <= r_mem[addr_i];
            end else begin
              r_state <= ST_MEM_WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end else if (w_io_rd && !w_rx_empty) begin
            r_state <= ST_ACK;
            r_ready <= 1'b1;
            r_data  <= w_rx_head;
          end else if (w_io_wr && !w_tx_full) begin
            r_state <= ST_ACK;
            r_ready <= 1'b1;
          end
`ifdef BF_BUS_PROTOCOL_CHECK_EN
          else if (w_illegal) begin
            r_state <= ST_ACK;
            r_ready <= 1'b1;
            r_nop   <= 1'b1;
            r_data  <= '0;
            r_err   <= 1'b1;
          end
`endif
        end
        ST_MEM_WAIT: begin
          if (!w_mem_req) r_state <= ST_IDLE;
          else if (r_cnt == '0) begin
            r_state <= ST_ACK;
            r_ready <= 1'b1;
            if (r_op == OP_MEM_RD) r_data <= r_mem[r_addr];
          end else r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (w_ram_we) r_mem[r_addr] <= data_i;
  bf_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n), .i_push(rx_valid), .i_data(rx_data), .i_pop(w_rx_pop),
    .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );
  bf_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .i_push(w_tx_push), .i_data(data_i), .i_pop(tx_ready),
    .o_head(tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );
endmodule

// File: tb/tb_bf_bus_responder.sv
// tb_bf_bus_responder: scoreboard bench for bf_bus_responder (RAM latency, RX stall, TX backpressure, reset abort).
module tb_bf_bus_responder;
  localparam int WS = 1;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] addr_i = '0, data_i = '0, rx_data = '0;
  logic       rd = 1'b0, wr = 1'b0, mreq = 1'b0, ioreq = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] data_o, tx_data;
  logic       ready, rx_ready, tx_valid;
`ifdef BF_BUS_PROTOCOL_CHECK_EN
  logic       err_o;
`endif
  int n_checks = 0, n_errors = 0;
  logic [7:0] ram_m [256];
  logic [7:0] exp_q [$];
  logic [7:0] tx_q [$];

  bf_bus_responder #(.DATA_ADDR_WIDTH(8), .FIFO_DEPTH(4), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .rd(rd), .wr(wr), .mreq(mreq), .ioreq(ioreq), .ready(ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef BF_BUS_PROTOCOL_CHECK_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one request at #1 after an edge, wait for ready, hold through the ACK cycle, then release
  task automatic bus(input logic m, io, r, w, input logic [7:0] a, d, output int lat, output logic [7:0] q);
    mreq = m; ioreq = io; rd = r; wr = w; addr_i = a; data_i = d; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 40);
    q = data_o;
    @(posedge clk); #1;
    {mreq, ioreq, rd, wr} = '0;
  endtask

  task automatic mem_wr(input logic [7:0] a, d);
    int lat; logic [7:0] q;
    bus(1'b1, 1'b0, 1'b0, 1'b1, a, d, lat, q);
    ram_m[a] = d;
    check("mem_wr_latency", lat, 1 + WS);
  endtask

  task automatic mem_rd(input logic [7:0] a);
    int lat; logic [7:0] q;
    exp_q.push_back(ram_m[a]);
    bus(1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00, lat, q);
    check("mem_rd_latency", lat, 1 + WS);
    check("mem_rd_data", q, exp_q.pop_front());
  endtask

  task automatic io_wr(input logic [7:0] d);
    int lat; logic [7:0] q;
    tx_q.push_back(d);
    bus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, d, lat, q);
    check("io_wr_latency", lat, 1);
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic rx_stall_check(input string tag);
    int n = 0;
    ioreq = 1'b1; rd = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    {ioreq, rd} = '0;
    check(tag, n, 0);
  endtask

  initial begin
    int n, prev, dbl, lat;
    logic [7:0] q;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", ready, 0);
    check("rst_data_o", data_o, 8'h00);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rx_ready", rx_ready, 1);

    for (int i = 0; i < 256; i++) mem_wr(8'(i), 8'h00);
    mem_rd(8'h05);

    mem_wr(8'h10, 8'h41);
    mem_wr(8'hFF, 8'h7E);
    mem_rd(8'h10);
    mem_rd(8'hFF);
    mem_rd(8'h10);

    ioreq = 1'b1; rd = 1'b1; n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    check("rx_empty_stall", n, 0);
    exp_q.push_back(8'h33);
    rx_data = 8'h33; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check("rx_ready_next_cycle", ready, 1);
    check("rx_data_o", data_o, exp_q.pop_front());
    @(posedge clk); #1;
    {ioreq, rd} = '0;
    rx_stall_check("rx_empty_after_pop");

    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) io_wr(8'(i));
    tx_q.push_back(8'h05);
    ioreq = 1'b1; wr = 1'b1; data_i = 8'h05; n = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    check("tx_full_stall", n, 0);
    check("tx_head_first", tx_data, tx_q.pop_front());
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    lat = 0;
    while (!ready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("tx_fifth_ack", ready, 1);
    @(posedge clk); #1;
    {ioreq, wr} = '0;
    for (int i = 0; i < 4; i++) begin
      check("tx_drain_valid", tx_valid, 1);
      check("tx_drain_data", tx_data, tx_q.size() != 0 ? tx_q.pop_front() : 8'hxx);
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
    check("tx_drained", tx_valid, 0);

    rx_push(8'hA0);
    rx_push(8'hA1);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    ioreq = 1'b1; rd = 1'b1; n = 0; prev = 0; dbl = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready) begin
        n++;
        if (prev != 0) dbl++;
        check("chain_rd_data", data_o, exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx);
      end
      prev = int'(ready);
    end
    {ioreq, rd} = '0;
    check("chain_rd_count", n, 2);
    check("chain_ready_pulse", dbl, 0);

    rx_push(8'h55);
    io_wr(8'h66);
    check("pre_rst_tx_valid", tx_valid, 1);
    mreq = 1'b1; wr = 1'b1; addr_i = 8'h20; data_i = 8'h99;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready, 0);
    check("midrst_data_o", data_o, 8'h00);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_rx_ready", rx_ready, 1);
    {mreq, wr} = '0;
    tx_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_stall_check("midrst_rx_empty");
    mem_rd(8'h20);
    mem_rd(8'hFF);

`ifdef BF_BUS_PROTOCOL_CHECK_EN
    mem_rd(8'h10);
    check("err_clear", err_o, 0);
    bus(1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, lat, q);
    check("illegal_latency", lat, 1);
    check("illegal_data_o", q, 8'h00);
    check("illegal_err", err_o, 1);
    mem_rd(8'h10);
    check("err_sticky", err_o, 1);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("err_reset", err_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
